priority_serializer: RTL and testbench



---
 rtl/priority_serializer_pkg.sv | 9 +
 rtl/priority_serializer_onehot.sv | 42 ++++
 rtl/priority_serializer.sv | 99 +++++++++
 tb/tb_priority_serializer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/priority_serializer_pkg.sv
// Shared types for the priority serializer: FSM state encoding.
package priority_serializer_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } ps_state_e;

endpackage : priority_serializer_pkg

// File: rtl/priority_serializer_onehot.sv
// Rightmost-set-bit isolator (priority_to_onehot_base) with a cumulative-valid flag.
// IMPLEMENTATION=0 uses two's-complement isolation; any other value uses a ripple scan.
module priority_to_onehot_base #(
  parameter int IMPLEMENTATION = 0,
  parameter int WIDTH          = 32
) (
  input  logic [WIDTH-1:0] dat_i,
  output logic [WIDTH-1:0] oht_o,
  output logic             vld_o
);

  generate
    if (IMPLEMENTATION == 0) begin : g_arith
      logic [WIDTH-1:0] neg_s;

      // Negation is WIDTH bits wide, carry-out discarded.
      always_comb begin
        neg_s = ~dat_i + WIDTH'(1);
        oht_o = dat_i & neg_s;
        vld_o = |dat_i;
      end
    end else begin : g_ripple
      logic [WIDTH-1:0] cum_s;

      always_comb begin
        oht_o = '0;
        cum_s = '0;
        for (int i = 0; i < WIDTH; i++) begin
          if (i == 0) begin
            oht_o[i] = dat_i[i];
            cum_s[i] = dat_i[i];
          end else begin
            oht_o[i] = dat_i[i] & ~cum_s[i-1];
            cum_s[i] = dat_i[i] | cum_s[i-1];
          end
        end
        vld_o = cum_s[WIDTH-1];
      end
    end
  endgenerate

endmodule : priority_to_onehot_base

// File: rtl/priority_serializer.sv
// Serializes a multi-hot request vector into one-hot grants, lowest index first.
// Optional gnt_idx port / binary encoder enabled by defining PRIORITY_SERIALIZER_INDEX_EN.
module priority_serializer
  import priority_serializer_pkg::*;
#(
  parameter  int WIDTH     = 32,
  localparam int WIDTH_LOG = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_vld,
  output logic                 req_rdy,
  input  logic [WIDTH-1:0]     req_dat,
  output logic                 gnt_vld,
  input  logic                 gnt_rdy,
  output logic [WIDTH-1:0]     gnt_oht,
`ifdef PRIORITY_SERIALIZER_INDEX_EN
  output logic [WIDTH_LOG-1:0] gnt_idx,
`endif
  output logic                 gnt_lst
);

  ps_state_e        state_q, state_d;
  logic [WIDTH-1:0] pnd_q, pnd_d;
  logic [WIDTH-1:0] oht_s;
  logic             any_s;
  logic             gnt_hs_s;
  logic             req_hs_s;

  priority_to_onehot_base #(
    .IMPLEMENTATION (0),
    .WIDTH          (WIDTH)
  ) u_onehot (
    .dat_i (pnd_q),
    .oht_o (oht_s),
    .vld_o (any_s)
  );

  // Grant outputs depend on pnd only; any_s gates gnt_lst low while idle (pnd=0).
  always_comb begin
    gnt_vld  = (state_q == BUSY);
    gnt_oht  = oht_s;
    gnt_lst  = any_s & ((pnd_q & ~oht_s) == '0);
    gnt_hs_s = gnt_vld & gnt_rdy;
    req_rdy  = (state_q == IDLE) | (gnt_hs_s & gnt_lst);
    req_hs_s = req_vld & req_rdy;
  end

`ifdef PRIORITY_SERIALIZER_INDEX_EN
  // One-hot to binary: OR of the indices of the set bits.
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (oht_s[i]) begin
        gnt_idx = gnt_idx | WIDTH_LOG'(i);
      end else begin
        gnt_idx = gnt_idx;
      end
    end
  end
`endif

  // A newly accepted vector overrides the retire of the final beat.
  always_comb begin
    state_d = state_q;
    pnd_d   = pnd_q;
    if (req_hs_s) begin
      if (req_dat != '0) begin
        state_d = BUSY;
        pnd_d   = req_dat;
      end else begin
        state_d = IDLE;
        pnd_d   = '0;
      end
    end else if (gnt_hs_s) begin
      if (gnt_lst) begin
        state_d = IDLE;
        pnd_d   = '0;
      end else begin
        state_d = BUSY;
        pnd_d   = pnd_q & ~oht_s;
      end
    end else begin
      state_d = state_q;
      pnd_d   = pnd_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pnd_q   <= '0;
    end else begin
      state_q <= state_d;
      pnd_q   <= pnd_d;
    end
  end

endmodule : priority_serializer

// File: tb/tb_priority_serializer.sv
// Self-checking bench for priority_serializer (WIDTH=8): directed table, reset cases, random vs queue model.
module tb_priority_serializer;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         req_vld;
  logic         req_rdy;
  logic [W-1:0] req_dat;
  logic         gnt_vld;
  logic         gnt_rdy;
  logic [W-1:0] gnt_oht;
  logic [2:0]   gnt_idx;
  logic         gnt_lst;

  int n_pass = 0;
  int n_tot  = 0;

  priority_serializer #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_vld (req_vld),
    .req_rdy (req_rdy),
    .req_dat (req_dat),
    .gnt_vld (gnt_vld),
    .gnt_rdy (gnt_rdy),
    .gnt_oht (gnt_oht),
`ifdef PRIORITY_SERIALIZER_INDEX_EN
    .gnt_idx (gnt_idx),
`endif
    .gnt_lst (gnt_lst)
  );

`ifndef PRIORITY_SERIALIZER_INDEX_EN
  assign gnt_idx = 3'd0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         vld;
    logic [W-1:0] dat;
    logic         rdy;
    logic         e_rr;
    logic         e_gv;
    logic [W-1:0] e_oht;
    logic [2:0]   e_idx;
    logic         e_lst;
  } vec_t;

  vec_t tbl[$];
  int   pq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic chk_outs(input string tag, input logic e_rr, input logic e_gv,
                          input logic [W-1:0] e_oht, input logic [2:0] e_idx, input logic e_lst);
    chk({tag, ".req_rdy"}, 32'(req_rdy), 32'(e_rr));
    chk({tag, ".gnt_vld"}, 32'(gnt_vld), 32'(e_gv));
    chk({tag, ".gnt_oht"}, 32'(gnt_oht), 32'(e_oht));
    chk({tag, ".gnt_lst"}, 32'(gnt_lst), 32'(e_lst));
`ifdef PRIORITY_SERIALIZER_INDEX_EN
    chk({tag, ".gnt_idx"}, 32'(gnt_idx), 32'(e_idx));
`else
    if (e_idx != e_idx) $display("unreachable");
`endif
  endtask

  function automatic vec_t mk(input logic v, input logic [W-1:0] d, input logic r, input logic rr,
                              input logic gv, input logic [W-1:0] o, input logic [2:0] ix, input logic l);
    vec_t t;
    t.vld = v; t.dat = d; t.rdy = r; t.e_rr = rr; t.e_gv = gv; t.e_oht = o; t.e_idx = ix; t.e_lst = l;
    return t;
  endfunction

  // Queue model: pending indices in ascending order; head is the current grant.
  task automatic model_cycle(input string tag, input logic v, input logic [W-1:0] d, input logic r);
    logic         e_gv, e_lst, e_rr;
    logic [W-1:0] e_oht;
    logic [W-1:0] one;
    logic [2:0]   e_idx;
    @(negedge clk);
    req_vld = v; req_dat = d; gnt_rdy = r;
    #1;
    one   = 8'd1;
    e_gv  = (pq.size() != 0);
    e_oht = e_gv ? (one << pq[0]) : 8'd0;
    e_idx = e_gv ? 3'(pq[0]) : 3'd0;
    e_lst = (pq.size() == 1);
    e_rr  = !e_gv || (r && e_lst);
    chk_outs(tag, e_rr, e_gv, e_oht, e_idx, e_lst);
    @(posedge clk);
    if (e_gv && r) void'(pq.pop_front());
    if (v && e_rr) begin
      for (int i = 0; i < W; i++) if (d[i]) pq.push_back(i);
    end
  endtask

  initial begin
    rst_n = 1'b0; req_vld = 1'b0; req_dat = 8'h00; gnt_rdy = 1'b0;

    // Reset held for 3 cycles.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_outs("reset", 1'b1, 1'b0, 8'h00, 3'd0, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // vld dat rdy | req_rdy gnt_vld oht idx lst
    tbl.push_back(mk(1'b1, 8'hA4, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h04, 3'd2, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h20, 3'd5, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h80, 3'd7, 1'b1));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0));
    tbl.push_back(mk(1'b1, 8'h06, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h02, 3'd1, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h02, 3'd1, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h02, 3'd1, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h02, 3'd1, 1'b0));
    tbl.push_back(mk(1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 8'h04, 3'd2, 1'b1));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h04, 3'd2, 1'b1));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0));
    tbl.push_back(mk(1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0));
    tbl.push_back(mk(1'b1, 8'h81, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0));
    tbl.push_back(mk(1'b1, 8'h10, 1'b1, 1'b0, 1'b1, 8'h01, 3'd0, 1'b0));
    tbl.push_back(mk(1'b1, 8'h10, 1'b1, 1'b1, 1'b1, 8'h80, 3'd7, 1'b1));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h10, 3'd4, 1'b1));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0));

    foreach (tbl[k]) begin
      @(negedge clk);
      req_vld = tbl[k].vld; req_dat = tbl[k].dat; gnt_rdy = tbl[k].rdy;
      #1;
      chk_outs($sformatf("tbl%0d", k), tbl[k].e_rr, tbl[k].e_gv, tbl[k].e_oht, tbl[k].e_idx, tbl[k].e_lst);
      @(posedge clk);
    end

    // Reset mid-vector: 0xFF, two grants taken, then async reset.
    @(negedge clk);
    req_vld = 1'b1; req_dat = 8'hFF; gnt_rdy = 1'b1;
    @(negedge clk);
    req_vld = 1'b0;
    #1 chk("midrst.first", 32'(gnt_oht), 32'h01);
    @(negedge clk);
    #1 chk("midrst.second", 32'(gnt_oht), 32'h02);
    #2 rst_n = 1'b0;
    #1;
    chk_outs("midrst.async", 1'b1, 1'b0, 8'h00, 3'd0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk_outs("midrst.rel", 1'b1, 1'b0, 8'h00, 3'd0, 1'b0);

    pq.delete();
    model_cycle("post1", 1'b1, 8'h01, 1'b1);
    model_cycle("post2", 1'b0, 8'h00, 1'b1);
    model_cycle("post3", 1'b0, 8'h00, 1'b1);

    // All-ones vector: WIDTH beats, last only on bit 7.
    model_cycle("ones", 1'b1, 8'hFF, 1'b1);
    for (int i = 0; i < W + 1; i++) model_cycle($sformatf("ones%0d", i), 1'b0, 8'h00, 1'b1);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      logic [W-1:0] d;
      d = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      if ($urandom_range(0, 9) == 0) d = 8'hFF;
      model_cycle($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), d, ($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule : tb_priority_serializer
